// File: rtl/genetico_serial_array_if.sv
// Handshake/bus bundle for genetico_serial_array: serial config, test-vector
// input and evaluation/fitness results.
`timescale 1ns/1ps
interface genetico_serial_array_if #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned FIT_W = 16
) ();
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_done;
  logic             in_valid;
  logic [N_IN-1:0]  chrom_in;
  logic [N_OUT-1:0] expected;
  logic             fit_clr;
  logic             out_valid;
  logic [N_OUT-1:0] chrom_out;
  logic [N_OUT-1:0] match;
  logic [FIT_W-1:0] fitness;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, chrom_in, expected, fit_clr,
    input  cfg_done, out_valid, chrom_out, match, fitness
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, chrom_in, expected, fit_clr,
    output cfg_done, out_valid, chrom_out, match, fitness
  );
endinterface

// File: rtl/genetico_serial_array.sv
// Serially configured feed-forward array of 2-input logic elements with a
// two-stage evaluation pipeline and a saturating match-count fitness register.
`timescale 1ns/1ps
module genetico_serial_array #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned N_LE  = 27,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned SEL_W = 6,
  parameter int unsigned FIT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  genetico_serial_array_if.slave  bus
);

  localparam int unsigned LE_W   = 3 + 2 * SEL_W;
  localparam int unsigned CFG_W  = N_LE * LE_W + N_OUT * SEL_W;
  localparam int unsigned POOL_W = 2 ** SEL_W;
  localparam int unsigned CNT_W  = $clog2(CFG_W);
  localparam int unsigned SUM_W  = FIT_W + $clog2(N_OUT + 1);

  typedef enum logic {ST_IDLE, ST_LOAD} state_t;

  state_t             r_state;
  logic [CFG_W-1:0]   r_shadow;
  logic [CFG_W-1:0]   r_active;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_done;

  logic               r_s1_valid;
  logic [N_IN-1:0]    r_s1_in;
  logic [N_OUT-1:0]   r_s1_exp;

  logic               r_out_valid;
  logic [N_OUT-1:0]   r_chrom_out;
  logic [N_OUT-1:0]   r_match;
  logic [FIT_W-1:0]   r_fitness;

  logic [CFG_W-1:0]   w_shadow_next;
  logic               w_commit;
  logic [N_OUT-1:0]   w_out;
  logic [SUM_W-1:0]   w_fit_sum;
  logic [FIT_W-1:0]   w_fit_next;

  // Unused pool slots stay 0, so selects pointing at later LEs or past the
  // last source read constant 0 and the array can never form a loop.
  function automatic logic [N_OUT-1:0] eval_array(input logic [CFG_W-1:0] cfg,
                                                  input logic [N_IN-1:0]  vin);
    logic [POOL_W-1:0] pool;
    logic [2:0]        func;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [SEL_W-1:0]  sel_o;
    logic              a;
    logic              b;
    logic              y;
    logic [N_OUT-1:0]  res;
    pool            = '0;
    pool[N_IN-1:0]  = vin;
    res             = '0;
    for (int k = 0; k < int'(N_LE); k++) begin
      func  = cfg[k*LE_W + 2*SEL_W +: 3];
      sel_a = cfg[k*LE_W + SEL_W +: SEL_W];
      sel_b = cfg[k*LE_W +: SEL_W];
      a     = pool[sel_a];
      b     = pool[sel_b];
      case (func)
        3'd0:    y = a & b;
        3'd1:    y = a | b;
        3'd2:    y = a ^ b;
        3'd3:    y = ~(a & b);
        3'd4:    y = ~(a | b);
        3'd5:    y = ~(a ^ b);
        3'd6:    y = ~a;
        default: y = a;
      endcase
      pool[N_IN + k] = y;
    end
    for (int m = 0; m < int'(N_OUT); m++) begin
      sel_o  = cfg[N_LE*LE_W + m*SEL_W +: SEL_W];
      res[m] = pool[sel_o];
    end
    return res;
  endfunction

  function automatic logic [SUM_W-1:0] popcount(input logic [N_OUT-1:0] v);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      s = s + SUM_W'(v[i]);
    end
    return s;
  endfunction

  assign w_shadow_next = {r_shadow[CFG_W-2:0], bus.cfg_bit};
  assign w_commit      = !bus.cfg_start && bus.cfg_valid &&
                         (r_cnt == CNT_W'(CFG_W - 1));
  assign w_out         = eval_array(r_active, r_s1_in);
  assign w_fit_sum     = SUM_W'(r_fitness) + popcount(r_match);
  assign w_fit_next    = (w_fit_sum > SUM_W'({FIT_W{1'b1}})) ? {FIT_W{1'b1}}
                                                             : w_fit_sum[FIT_W-1:0];

  // Bitstream loader; the final accepted bit commits shadow to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_active   <= '0;
      r_cnt      <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      if (bus.cfg_start) begin
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else if (bus.cfg_valid) begin
        r_shadow <= w_shadow_next;
        if (w_commit) begin
          r_active   <= w_shadow_next;
          r_cnt      <= '0;
          r_state    <= ST_IDLE;
          r_cfg_done <= 1'b1;
        end else begin
          r_cnt   <= (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
          r_state <= ST_LOAD;
        end
      end
    end
  end

  // Two-stage evaluation pipeline plus fitness accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_in     <= '0;
      r_s1_exp    <= '0;
      r_out_valid <= 1'b0;
      r_chrom_out <= '0;
      r_match     <= '0;
      r_fitness   <= '0;
    end else begin
      r_s1_valid  <= bus.in_valid;
      r_s1_in     <= bus.chrom_in;
      r_s1_exp    <= bus.expected;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_chrom_out <= w_out;
        r_match     <= ~(w_out ^ r_s1_exp);
      end
      if (w_commit || bus.fit_clr) begin
        r_fitness <= '0;
      end else if (r_out_valid) begin
        r_fitness <= w_fit_next;
      end
    end
  end

  assign bus.cfg_done  = r_cfg_done;
  assign bus.out_valid = r_out_valid;
  assign bus.chrom_out = r_chrom_out;
  assign bus.match     = r_match;
  assign bus.fitness   = r_fitness;

endmodule

// File: tb/tb_genetico_serial_array.sv
// Directed bench for genetico_serial_array: a default instance plus a
// FIT_W=4 instance sharing the same stimulus for the saturation check.
`timescale 1ns/1ps
module tb_genetico_serial_array;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned N_LE  = 27;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 6;
  localparam int unsigned LE_W  = 3 + 2 * SEL_W;
  localparam int unsigned CFG_W = N_LE * LE_W + N_OUT * SEL_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  genetico_serial_array_if #(.N_IN(N_IN), .N_OUT(N_OUT), .FIT_W(16)) mif ();
  genetico_serial_array_if #(.N_IN(N_IN), .N_OUT(N_OUT), .FIT_W(4))  sif ();

  assign sif.cfg_start = mif.cfg_start;
  assign sif.cfg_valid = mif.cfg_valid;
  assign sif.cfg_bit   = mif.cfg_bit;
  assign sif.in_valid  = mif.in_valid;
  assign sif.chrom_in  = mif.chrom_in;
  assign sif.expected  = mif.expected;
  assign sif.fit_clr   = mif.fit_clr;

  genetico_serial_array #(.N_IN(N_IN), .N_LE(N_LE), .N_OUT(N_OUT), .SEL_W(SEL_W), .FIT_W(16))
    dut (.clk(clk), .rst(rst), .bus(mif));
  genetico_serial_array #(.N_IN(N_IN), .N_LE(N_LE), .N_OUT(N_OUT), .SEL_W(SEL_W), .FIT_W(4))
    dut_sat (.clk(clk), .rst(rst), .bus(sif));

  always @(negedge clk) if (mif.cfg_done === 1'b1) done_cnt++;

  // LE0 = {f0, a0, b0}; every other LE left at AND(src0, src0).
  function automatic logic [CFG_W-1:0] make_cfg(input logic [2:0] f0, input logic [5:0] a0,
                                                 input logic [5:0] b0, input logic [5:0] o0,
                                                 input logic [5:0] o1, input logic [5:0] o2,
                                                 input logic [5:0] o3);
    logic [CFG_W-1:0] c;
    c = '0;
    c[0 +: LE_W] = {f0, a0, b0};
    c[N_LE*LE_W + 0*SEL_W +: SEL_W] = o0;
    c[N_LE*LE_W + 1*SEL_W +: SEL_W] = o1;
    c[N_LE*LE_W + 2*SEL_W +: SEL_W] = o2;
    c[N_LE*LE_W + 3*SEL_W +: SEL_W] = o3;
    return c;
  endfunction

  task automatic send_stream(input logic [CFG_W-1:0] cfg, input int nbits, input int gap,
                             input logic want_done);
    for (int i = 0; i < nbits; i++) begin
      if (gap != 0 && i != 0 && (i % gap) == 0) begin
        @(negedge clk);
        mif.cfg_valid = 1'b0;
      end
      @(negedge clk);
      mif.cfg_valid = 1'b1;
      mif.cfg_bit   = cfg[CFG_W-1-i];
    end
    @(negedge clk);
    mif.cfg_valid = 1'b0;
    checks++;
    if (mif.cfg_done !== want_done) begin
      errors++;
      $display("FAIL stream_done: got %b want %b", mif.cfg_done, want_done);
    end
  endtask

  task automatic eval_vec(input logic [7:0] vin, input logic [3:0] vexp, input logic [3:0] want_out,
                          input logic [15:0] want_fit, input string name);
    logic [3:0] want_match;
    want_match = ~(want_out ^ vexp);
    @(negedge clk);
    mif.in_valid = 1'b1;
    mif.chrom_in = vin;
    mif.expected = vexp;
    @(negedge clk);
    mif.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mif.out_valid !== 1'b1 || mif.chrom_out !== want_out || mif.match !== want_match) begin
      errors++;
      $display("FAIL %s_out: valid=%b out=%h match=%h want valid=1 out=%h match=%h",
               name, mif.out_valid, mif.chrom_out, mif.match, want_out, want_match);
    end
    @(negedge clk);
    checks++;
    if (mif.fitness !== want_fit) begin
      errors++;
      $display("FAIL %s_fit: got %0d want %0d", name, mif.fitness, want_fit);
    end
  endtask

  task automatic test_reset();
    mif.cfg_start = 1'b0; mif.cfg_valid = 1'b0; mif.cfg_bit = 1'b0;
    mif.in_valid  = 1'b0; mif.chrom_in  = '0;   mif.expected = '0;
    mif.fit_clr   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mif.cfg_done !== 1'b0 || mif.out_valid !== 1'b0 || mif.chrom_out !== 4'h0 ||
        mif.match !== 4'h0 || mif.fitness !== 16'h0) begin
      errors++;
      $display("FAIL reset: done=%b valid=%b out=%h match=%h fit=%0d want all 0",
               mif.cfg_done, mif.out_valid, mif.chrom_out, mif.match, mif.fitness);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_config();
    eval_vec(8'hA5, 4'hF, 4'hF, 16'd4, "zero_cfg");
  endtask

  task automatic test_load();
    int d0;
    d0 = done_cnt;
    send_stream(make_cfg(3'd2, 6'd0, 6'd1, 6'd8, 6'd8, 6'd8, 6'd8), CFG_W, 100, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL load_done_count: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (mif.fitness !== 16'd0) begin
      errors++;
      $display("FAIL load_fit_clear: got %0d want 0", mif.fitness);
    end
    eval_vec(8'h01, 4'hF, 4'hF, 16'd4, "xor_01");
    eval_vec(8'h03, 4'hF, 4'h0, 16'd4, "xor_03");
  endtask

  task automatic test_feed_forward();
    send_stream(make_cfg(3'd7, 6'd8, 6'd0, 6'd63, 6'd0, 6'd8, 6'd8), CFG_W, 0, 1'b1);
    eval_vec(8'hFF, 4'h0, 4'b0010, 16'd3, "ff_ones");
    eval_vec(8'h00, 4'h0, 4'b0000, 16'd7, "ff_zeros");
  endtask

  task automatic test_interrupted();
    int d0;
    d0 = done_cnt;
    send_stream({CFG_W{1'b1}}, 200, 64, 1'b0);
    @(negedge clk);
    mif.cfg_start = 1'b1;
    mif.cfg_valid = 1'b1;
    mif.cfg_bit   = 1'b1;
    @(negedge clk);
    mif.cfg_start = 1'b0;
    mif.cfg_valid = 1'b0;
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL intr_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    send_stream(make_cfg(3'd2, 6'd0, 6'd1, 6'd8, 6'd8, 6'd8, 6'd8), CFG_W, 0, 1'b1);
    eval_vec(8'h01, 4'h0, 4'hF, 16'd0, "intr_01");
    eval_vec(8'h03, 4'h0, 4'h0, 16'd4, "intr_03");
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL intr_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    mif.fit_clr = 1'b1;
    @(negedge clk);
    mif.fit_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mif.in_valid = 1'b1;
      mif.chrom_in = 8'h01;
      mif.expected = 4'hF;
      @(negedge clk);
    end
    mif.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sif.fitness !== 4'd15 || mif.fitness !== 16'd16) begin
      errors++;
      $display("FAIL sat_fit: got sat=%0d wide=%0d want sat=15 wide=16", sif.fitness, mif.fitness);
    end
    @(negedge clk);
    mif.in_valid = 1'b1;
    @(negedge clk);
    mif.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mif.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_valid: got %b want 1", mif.out_valid);
    end
    mif.fit_clr = 1'b1;
    @(negedge clk);
    mif.fit_clr = 1'b0;
    checks++;
    if (sif.fitness !== 4'd0 || mif.fitness !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority: got sat=%0d wide=%0d want 0", sif.fitness, mif.fitness);
    end
  endtask

  task automatic test_back_to_back();
    eval_vec(8'h01, 4'hF, 4'hF, 16'd4, "pre_commit");
    fork
      send_stream('0, CFG_W, 0, 1'b1);
      begin
        repeat (CFG_W - 1) @(negedge clk);
        mif.in_valid = 1'b1; mif.chrom_in = 8'h03; mif.expected = 4'h0;
        @(negedge clk);
        mif.chrom_in = 8'h03; mif.expected = 4'hF;
        checks++;
        if (mif.fitness !== 16'd4) begin
          errors++;
          $display("FAIL b2b_fit_before: got %0d want 4", mif.fitness);
        end
        @(negedge clk);
        mif.in_valid = 1'b0;
        checks++;
        if (mif.out_valid !== 1'b1 || mif.chrom_out !== 4'h0 || mif.fitness !== 16'd0) begin
          errors++;
          $display("FAIL b2b_old_cfg: valid=%b out=%h fit=%0d want valid=1 out=0 fit=0",
                   mif.out_valid, mif.chrom_out, mif.fitness);
        end
        @(negedge clk);
        checks++;
        if (mif.out_valid !== 1'b1 || mif.chrom_out !== 4'hF || mif.fitness !== 16'd4) begin
          errors++;
          $display("FAIL b2b_new_cfg: valid=%b out=%h fit=%0d want valid=1 out=f fit=4",
                   mif.out_valid, mif.chrom_out, mif.fitness);
        end
        @(negedge clk);
        checks++;
        if (mif.fitness !== 16'd8) begin
          errors++;
          $display("FAIL b2b_fit_after: got %0d want 8", mif.fitness);
        end
      end
    join
  endtask

  task automatic test_reset_mid_load();
    int d0;
    d0 = done_cnt;
    send_stream({CFG_W{1'b1}}, 100, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mif.fitness !== 16'd0 || mif.out_valid !== 1'b0 || mif.chrom_out !== 4'h0 ||
        mif.cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: fit=%0d valid=%b out=%h done=%b want all 0",
               mif.fitness, mif.out_valid, mif.chrom_out, mif.cfg_done);
    end
    rst = 1'b0;
    send_stream({CFG_W{1'b1}}, CFG_W - 100, 0, 1'b0);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d pulses want 0", done_cnt - d0);
    end
    @(negedge clk);
    mif.cfg_start = 1'b1;
    @(negedge clk);
    mif.cfg_start = 1'b0;
    eval_vec(8'hA5, 4'hF, 4'hF, 16'd4, "post_reset");
  endtask

  initial begin
    test_reset();
    test_zero_config();
    test_load();
    test_feed_forward();
    test_interrupted();
    test_saturation();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
